// File: rtl/event_batcher_pkg.sv
// Shared types and header layout for the event stream batcher.
package event_batcher_pkg;

  localparam logic [3:0]  HDR_MAGIC = 4'hA;
  localparam int unsigned SEQ_W     = 8;
  localparam int unsigned PKT_W     = 8;
  localparam int unsigned WCNT_W    = 12;
  localparam int unsigned WCNT_LSB  = 0;
  localparam int unsigned PKT_LSB   = WCNT_LSB + WCNT_W;
  localparam int unsigned SEQ_LSB   = PKT_LSB + PKT_W;
  localparam int unsigned MAGIC_LSB = SEQ_LSB + SEQ_W;
  localparam int unsigned HDR_W     = MAGIC_LSB + 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
`ifdef EVENT_BATCHER_TRAILER_EN
    ST_TRAILER = 3'd3,
`endif
    ST_DISCARD = 3'd4
  } state_e;

  function automatic logic [HDR_W-1:0] make_header(input logic [SEQ_W-1:0]  seq,
                                                   input logic [PKT_W-1:0]  pkts,
                                                   input logic [WCNT_W-1:0] wcnt);
    logic [HDR_W-1:0] w;
    w = '0;
    w[MAGIC_LSB +: 4]     = HDR_MAGIC;
    w[SEQ_LSB   +: SEQ_W] = seq;
    w[PKT_LSB   +: PKT_W] = pkts;
    w[WCNT_LSB  +: WCNT_W] = wcnt;
    return w;
  endfunction

endpackage

// File: rtl/event_stream_batcher_if.sv
// AXI-stream style handshake bundle used on both sides of the batcher.
interface event_stream_batcher_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/batcher_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the head whenever !empty.
module batcher_sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/event_stream_batcher.sv
// Packs whole tlast-delimited event packets into headered batches with a sequence number.
// Optional XOR trailer word per batch when EVENT_BATCHER_TRAILER_EN is defined.
module event_stream_batcher
  import event_batcher_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH     = 256,
  parameter int unsigned BATCH_PACKETS  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   flush,
  event_stream_batcher_if.slave  s_axis,
  event_stream_batcher_if.master m_axis,
  output logic                   overflow_err
);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW       = TDATA_WIDTH + 1;
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [PKT_W-1:0]   b_pkts_q, b_pkts_d;
  logic [CNT_W-1:0]   b_words_q, b_words_d;
  logic [CNT_W-1:0]   cur_words_q, cur_words_d;
  logic [CNT_W-1:0]   pend_pkts_q, pend_pkts_d;
  logic [PKT_W-1:0]   acc_pkts_q, acc_pkts_d;
  logic [CNT_W-1:0]   acc_words_q, acc_words_d;
  logic [31:0]        tmo_q, tmo_d;
  logic               ovf_q, ovf_d;
  logic               alive_q;
`ifdef EVENT_BATCHER_TRAILER_EN
  logic [TDATA_WIDTH-1:0] xor_q, xor_d;
`endif

  logic                   fifo_clear_c, fifo_push_c, fifo_pop_c, fifo_full, fifo_empty;
  logic [FW-1:0]          fifo_head;
  logic                   lenq_push_c, lenq_pop_c, lenq_full, lenq_empty;
  logic [CNT_W-1:0]       lenq_din_c, lenq_head;
  logic                   close_c, timeout_c, s_ready_c, store_c, pkt_done_c, last_word_c;
  logic                   m_valid_c, m_last_c;
  logic [TDATA_WIDTH-1:0] m_data_c;
  logic [HDR_W-1:0]       hdr_c;
  logic [PKT_W-1:0]       base_pkts_c;
  logic [CNT_W-1:0]       base_words_c, pkt_words_c;

  batcher_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(resetn), .clear(fifo_clear_c),
    .push(fifo_push_c), .din({s_axis.tlast, s_axis.tdata}),
    .pop(fifo_pop_c), .dout(fifo_head), .full(fifo_full), .empty(fifo_empty)
  );

  // Word counts of pending batches that already reached BATCH_PACKETS packets;
  // partial batches live in the acc_* registers.
  batcher_sync_fifo #(.WIDTH(CNT_W), .DEPTH(FIFO_DEPTH)) u_lenq (
    .clk(clk), .rst_n(resetn), .clear(fifo_clear_c),
    .push(lenq_push_c), .din(lenq_din_c),
    .pop(lenq_pop_c), .dout(lenq_head), .full(lenq_full), .empty(lenq_empty)
  );

  assign timeout_c = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
  assign hdr_c     = make_header(seq_q, b_pkts_q, WCNT_W'(b_words_q));

  // FSM next state and output stream
  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    b_pkts_d     = b_pkts_q;
    b_words_d    = b_words_q;
    ovf_d        = ovf_q;
    fifo_clear_c = 1'b0;
    fifo_pop_c   = 1'b0;
    lenq_pop_c   = 1'b0;
    close_c      = 1'b0;
    m_valid_c    = 1'b0;
    m_data_c     = '0;
    m_last_c     = 1'b0;
    last_word_c  = 1'b0;
`ifdef EVENT_BATCHER_TRAILER_EN
    xor_d        = xor_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable && (pend_pkts_q != '0) &&
            ((32'(pend_pkts_q) >= BATCH_PACKETS) || timeout_c || flush || fifo_full)) begin
          close_c    = 1'b1;
          lenq_pop_c = !lenq_empty;
          b_pkts_d   = lenq_empty ? acc_pkts_q  : PKT_W'(BATCH_PACKETS);
          b_words_d  = lenq_empty ? acc_words_q : lenq_head;
          state_d    = ST_HEADER;
        end else if (fifo_full && (pend_pkts_q == '0)) begin
          ovf_d        = 1'b1;
          fifo_clear_c = 1'b1;
          state_d      = ST_DISCARD;
        end
      end
      ST_HEADER: begin
        m_valid_c = 1'b1;
        m_data_c  = TDATA_WIDTH'(hdr_c);
`ifdef EVENT_BATCHER_TRAILER_EN
        xor_d     = '0;
`endif
        if (m_axis.tready) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        m_valid_c   = !fifo_empty;
        m_data_c    = fifo_head[TDATA_WIDTH-1:0];
        last_word_c = fifo_head[TDATA_WIDTH] && (b_pkts_q == PKT_W'(1));
`ifndef EVENT_BATCHER_TRAILER_EN
        m_last_c    = last_word_c;
`endif
        if (m_valid_c && m_axis.tready) begin
          fifo_pop_c = 1'b1;
`ifdef EVENT_BATCHER_TRAILER_EN
          xor_d      = xor_q ^ m_data_c;
`endif
          if (fifo_head[TDATA_WIDTH]) b_pkts_d = b_pkts_q - PKT_W'(1);
          if (last_word_c) begin
            seq_d = seq_q + SEQ_W'(1);
`ifdef EVENT_BATCHER_TRAILER_EN
            state_d = ST_TRAILER;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef EVENT_BATCHER_TRAILER_EN
      ST_TRAILER: begin
        m_valid_c = 1'b1;
        m_data_c  = xor_q;
        m_last_c  = 1'b1;
        if (m_axis.tready) state_d = ST_IDLE;
      end
`endif
      ST_DISCARD: begin
        if (s_axis.tvalid && s_axis.tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Input acceptance, packet bookkeeping and timeout counter
  always_comb begin
    s_ready_c   = alive_q && ((state_q == ST_DISCARD) || (enable && !fifo_full && !lenq_full));
    store_c     = s_axis.tvalid && s_ready_c && (state_q != ST_DISCARD);
    pkt_done_c  = store_c && s_axis.tlast;
    fifo_push_c = store_c;
    pkt_words_c = cur_words_q + CNT_W'(1);

    cur_words_d = cur_words_q;
    if (fifo_clear_c || pkt_done_c) cur_words_d = '0;
    else if (store_c)               cur_words_d = pkt_words_c;

    // A closing partial batch empties the accumulator before any new packet joins.
    base_pkts_c  = (close_c && lenq_empty) ? '0 : acc_pkts_q;
    base_words_c = (close_c && lenq_empty) ? '0 : acc_words_q;
    acc_pkts_d   = base_pkts_c;
    acc_words_d  = base_words_c;
    lenq_push_c  = 1'b0;
    lenq_din_c   = base_words_c + pkt_words_c;
    if (pkt_done_c) begin
      if (32'(base_pkts_c) + 32'd1 == BATCH_PACKETS) begin
        lenq_push_c = 1'b1;
        acc_pkts_d  = '0;
        acc_words_d = '0;
      end else begin
        acc_pkts_d  = base_pkts_c + PKT_W'(1);
        acc_words_d = lenq_din_c;
      end
    end

    pend_pkts_d = pend_pkts_q - (close_c ? CNT_W'(b_pkts_d) : CNT_W'(0))
                              + (pkt_done_c ? CNT_W'(1) : CNT_W'(0));

    tmo_d = tmo_q;
    if ((state_q != ST_IDLE) || (pend_pkts_q == '0)) tmo_d = '0;
    else if (tmo_q != TMO_LAST)                       tmo_d = tmo_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      seq_q       <= '0;
      b_pkts_q    <= '0;
      b_words_q   <= '0;
      cur_words_q <= '0;
      pend_pkts_q <= '0;
      acc_pkts_q  <= '0;
      acc_words_q <= '0;
      tmo_q       <= '0;
      ovf_q       <= 1'b0;
      alive_q     <= 1'b0;
`ifdef EVENT_BATCHER_TRAILER_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      b_pkts_q    <= b_pkts_d;
      b_words_q   <= b_words_d;
      cur_words_q <= cur_words_d;
      pend_pkts_q <= pend_pkts_d;
      acc_pkts_q  <= acc_pkts_d;
      acc_words_q <= acc_words_d;
      tmo_q       <= tmo_d;
      ovf_q       <= ovf_d;
      alive_q     <= 1'b1;
`ifdef EVENT_BATCHER_TRAILER_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign s_axis.tready = s_ready_c;
  assign m_axis.tvalid = m_valid_c;
  assign m_axis.tdata  = m_data_c;
  assign m_axis.tlast  = m_last_c;
  assign overflow_err  = ovf_q;
endmodule

// File: tb/tb_event_stream_batcher.sv
// Directed scoreboard bench for event_stream_batcher (BATCH=4, TIMEOUT=1000, DEPTH=16).
module tb_event_stream_batcher;
  localparam int unsigned TMO = 1000;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk, resetn, enable, flush, overflow_err;
  event_stream_batcher_if #(.DATA_W(32)) s_if ();
  event_stream_batcher_if #(.DATA_W(32)) m_if ();

  event_stream_batcher #(
    .TDATA_WIDTH(32), .FIFO_DEPTH(16), .BATCH_PACKETS(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .flush(flush),
    .s_axis(s_if), .m_axis(m_if), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks, errors, popped, exp_seq;
  bit   rand_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] hdr(input int seq, input int p, input int w);
    return {4'hA, 8'(seq), 8'(p), 12'(w)};
  endfunction

  // Handshake check on the falling edge: stalls must hold data, accepted words pop the scoreboard.
  task automatic monitor();
    logic stall, pl;
    logic [31:0] pd;
    exp_t e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) stall = 1'b0;
      else begin
        if (stall) begin
          chk("stall_valid", 32'(m_if.tvalid), 32'd1);
          chk("stall_data", m_if.tdata, pd);
          chk("stall_last", 32'(m_if.tlast), 32'(pl));
        end
        if (m_if.tvalid && m_if.tready) begin
          chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", m_if.tdata, e.data);
            chk("out_last", 32'(m_if.tlast), 32'(e.last));
          end
          popped++;
        end
        stall = m_if.tvalid && !m_if.tready;
        pd    = m_if.tdata;
        pl    = m_if.tlast;
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_if.tready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    logic hs;
    int n;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = l;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = s_if.tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) chk("s_handshake", 32'(hs), 32'd1);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // Queue the expected batch (header, payload, optional trailer) then drive its packets.
  task automatic run_batch(input int npkts, input int wpp, input logic [31:0] base);
    logic [31:0] x, d;
    logic l;
    x = '0;
    exp_q.push_back('{hdr(exp_seq, npkts, npkts * wpp), 1'b0});
    for (int p = 0; p < npkts; p++)
      for (int w = 0; w < wpp; w++) begin
        d = base + 32'(p * wpp + w);
        l = (p == npkts - 1) && (w == wpp - 1);
        x = x ^ d;
`ifdef EVENT_BATCHER_TRAILER_EN
        exp_q.push_back('{d, 1'b0});
`else
        exp_q.push_back('{d, l});
`endif
      end
`ifdef EVENT_BATCHER_TRAILER_EN
    exp_q.push_back('{x, 1'b1});
`endif
    exp_seq++;
    for (int p = 0; p < npkts; p++)
      for (int w = 0; w < wpp; w++)
        send_word(base + 32'(p * wpp + w), 1'(w == wpp - 1));
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    exp_q.delete();
    repeat (3) step();
    resetn  = 1'b1;
    exp_seq = 0;
    step();
  endtask

  initial begin
    int n, p0, saw;
    checks = 0; errors = 0; popped = 0; exp_seq = 0; rand_rdy = 1'b0;
    resetn = 1'b0; enable = 1'b1; flush = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    fork
      monitor();
      ready_driver();
    join_none
    repeat (3) step();
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_m_tdata", m_if.tdata, 32'd0);
    chk("rst_s_tready", 32'(s_if.tready), 32'd0);
    chk("rst_overflow", 32'(overflow_err), 32'd0);
    resetn = 1'b1;
    step();
    chk("s_tready_enabled", 32'(s_if.tready), 32'd1);
    enable = 1'b0;
    #1;
    chk("s_tready_disabled", 32'(s_if.tready), 32'd0);
    enable = 1'b1;
    step();

    // Case 1: one full batch of 4x3 words
    run_batch(4, 3, 32'h1000_0000);
    wait_drain("case1_drain");

    // Case 2: two back-to-back batches
    run_batch(4, 3, 32'h2000_0000);
    run_batch(4, 3, 32'h2100_0000);
    wait_drain("case2_drain");

    // Case 4: same traffic with random output backpressure
    rand_rdy = 1'b1;
    run_batch(4, 3, 32'h4000_0000);
    run_batch(4, 3, 32'h4100_0000);
    wait_drain("case4_drain");
    rand_rdy = 1'b0;
    m_if.tready = 1'b1;
    step();

    // Case 3: lone packet forced out by timeout; tlast cycle counts as cycle 0
    run_batch(1, 3, 32'h3000_0000);
    n = 0;
    while (!m_if.tvalid && n < 1200) begin
      step();
      n++;
    end
    chk("timeout_latency", 32'(n), 32'(TMO));
    wait_drain("case3_drain");

    // Flush with nothing buffered produces no output
    flush = 1'b1;
    step();
    flush = 1'b0;
    saw = 0;
    repeat (50) begin
      step();
      if (m_if.tvalid) saw++;
    end
    chk("flush_empty_quiet", 32'(saw), 32'd0);

    // Case 5: oversize packet is dropped and flagged
    do_reset();
    for (int w = 0; w < 20; w++) send_word(32'h5000_0000 + 32'(w), 1'(w == 19));
    chk("overflow_set", 32'(overflow_err), 32'd1);
    chk("overflow_hdr_value", hdr(exp_seq, 1, 3), 32'hA000_1003);
    run_batch(1, 3, 32'h5100_0000);
    wait_drain("case5_drain");
    chk("overflow_sticky", 32'(overflow_err), 32'd1);

    // Case 6: reset in the middle of a payload
    run_batch(4, 3, 32'h6000_0000);
    p0 = popped;
    n  = 0;
    while (popped < p0 + 4 && n < 200) begin
      step();
      n++;
    end
    chk("mid_payload_reached", 32'(popped >= p0 + 4), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("reset_drops_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("reset_clears_tdata", m_if.tdata, 32'd0);
    exp_q.delete();
    step();
    step();
    resetn  = 1'b1;
    exp_seq = 0;
    step();
    chk("reset_clears_overflow", 32'(overflow_err), 32'd0);
    run_batch(1, 3, 32'h6100_0000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_drain("case6_drain");
    repeat (20) step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
